// File: rtl/ula_mul_div_seq_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
//   estado_t   : FSM states of the top (OCIOSO, CALCULA, ESCREVE)
//   operacao_t : Operacao encodings (MUL low/high half, DIV quotient/remainder)
//   default operand width and register-bank address width
package ula_mul_div_pkg;

    localparam int unsigned BITS_PALAVRA_PAD  = 16;
    localparam int unsigned END_REGISTROS_PAD = 2;

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULA,
        ESCREVE
    } estado_t;

    typedef enum logic [1:0] {
        OP_MUL_LO = 2'b00,
        OP_MUL_HI = 2'b01,
        OP_DIV_Q  = 2'b10,
        OP_DIV_R  = 2'b11
    } operacao_t;

endpackage

// File: rtl/ula_mul_div_seq_nucleo.sv
// Single iteration of the shift-add multiplier / restoring divider.
// Purely combinational; the top holds the state and calls this once per
// CALCULA cycle.
//   modo_div : 0 = shift-add multiply step, 1 = restore-subtract divide step
//   acc      : MUL upper product half / DIV partial remainder
//   lo       : MUL lower product half (multiplier shifts out) /
//              DIV dividend shifting out, quotient shifting in
//   operando : MUL multiplicand / DIV divisor
//   acc_prox, lo_prox : register values after this iteration
module nucleo_passo_mul_div
    import ula_mul_div_pkg::*;
#(
    parameter int unsigned bits_palavra = BITS_PALAVRA_PAD
) (
    input  logic                    modo_div,
    input  logic [bits_palavra-1:0] acc,
    input  logic [bits_palavra-1:0] lo,
    input  logic [bits_palavra-1:0] operando,
    output logic [bits_palavra-1:0] acc_prox,
    output logic [bits_palavra-1:0] lo_prox
);

    logic [bits_palavra:0] soma;
    logic [bits_palavra:0] desloc;
    logic [bits_palavra:0] dif;

    always_comb begin
        soma     = {1'b0, acc} + (lo[0] ? {1'b0, operando} : '0);
        desloc   = {acc, lo[bits_palavra-1]};
        dif      = desloc - {1'b0, operando};
        acc_prox = '0;
        lo_prox  = '0;
        if (modo_div) begin
            // Remainder stays below the divisor, so desloc <= 2*divisor-1 and
            // a non-negative difference never sets the top bit: dif[W] is the borrow.
            if (!dif[bits_palavra]) begin
                acc_prox = dif[bits_palavra-1:0];
                lo_prox  = {lo[bits_palavra-2:0], 1'b1};
            end else begin
                acc_prox = desloc[bits_palavra-1:0];
                lo_prox  = {lo[bits_palavra-2:0], 1'b0};
            end
        end else begin
            // Carry of the add falls into the upper half as the pair shifts right.
            acc_prox = soma[bits_palavra:1];
            lo_prox  = {soma[0], lo[bits_palavra-1:1]};
        end
    end

endmodule

// File: rtl/ula_mul_div_seq.sv
// Multi-cycle unsigned multiply/divide unit feeding the register bank.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   Inicia        : start request, accepted only while idle
//   Operacao      : 00 MUL low, 01 MUL high, 10 DIV quotient, 11 DIV remainder
//   A, B          : operands from bank read ports A/B
//   Sel_Destino   : destination register of the result
//   Ocupado       : operation in progress
//   Pronto        : one-cycle completion pulse (with Hab_Escrita)
//   Resultado     : write-back word to bank input E, held between operations
//   Hab_Escrita   : one-cycle bank write strobe
//   Sel_SC        : latched destination to the bank, held between operations
//   Div_Zero      : flags a DIV with B==0, alongside Pronto
module ula_mul_div_seq
    import ula_mul_div_pkg::*;
#(
    parameter int unsigned bits_palavra  = BITS_PALAVRA_PAD,
    parameter int unsigned end_registros = END_REGISTROS_PAD
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     Inicia,
    input  logic [1:0]               Operacao,
    input  logic [bits_palavra-1:0]  A,
    input  logic [bits_palavra-1:0]  B,
    input  logic [end_registros-1:0] Sel_Destino,
    output logic                     Ocupado,
    output logic                     Pronto,
    output logic [bits_palavra-1:0]  Resultado,
    output logic                     Hab_Escrita,
    output logic [end_registros-1:0] Sel_SC,
    output logic                     Div_Zero
);

    localparam int unsigned CW = $clog2(bits_palavra + 1);

    estado_t                  estado, prox_estado;
    logic [CW-1:0]            cont;
    operacao_t                reg_op;
    logic [end_registros-1:0] reg_dest;
    logic                     reg_dz;
    logic [bits_palavra-1:0]  reg_operando;
    logic [bits_palavra-1:0]  acc, lo;
    logic [bits_palavra-1:0]  acc_prox, lo_prox;
    logic                     dz_entrada;
    logic [bits_palavra-1:0]  selecionado;

    assign dz_entrada = Operacao[1] && (B == '0);
    assign Ocupado    = (estado != OCIOSO);

    nucleo_passo_mul_div #(
        .bits_palavra(bits_palavra)
    ) u_nucleo (
        .modo_div (reg_op[1]),
        .acc      (acc),
        .lo       (lo),
        .operando (reg_operando),
        .acc_prox (acc_prox),
        .lo_prox  (lo_prox)
    );

    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox_estado;
    end

    always_comb begin
        prox_estado = estado;
        unique case (estado)
            OCIOSO:  if (Inicia) prox_estado = dz_entrada ? ESCREVE : CALCULA;
            CALCULA: if (cont == CW'(1)) prox_estado = ESCREVE;
            ESCREVE: prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    always_comb begin
        selecionado = '0;
        unique case (reg_op)
            OP_MUL_LO, OP_DIV_Q: selecionado = lo;
            OP_MUL_HI, OP_DIV_R: selecionado = acc;
            default:             selecionado = '0;
        endcase
    end

    // Only one operand needs holding: the multiplier (MUL) or dividend (DIV)
    // goes straight into lo. Divide by zero preloads the fixed answers
    // (quotient all ones, remainder A) so ESCREVE selects uniformly.
    always_ff @(posedge clock) begin
        if (reset) begin
            cont         <= '0;
            reg_op       <= OP_MUL_LO;
            reg_dest     <= '0;
            reg_dz       <= 1'b0;
            reg_operando <= '0;
            acc          <= '0;
            lo           <= '0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (Inicia) begin
                        cont         <= CW'(bits_palavra);
                        reg_op       <= operacao_t'(Operacao);
                        reg_dest     <= Sel_Destino;
                        reg_dz       <= dz_entrada;
                        reg_operando <= Operacao[1] ? B : A;
                        if (dz_entrada) begin
                            acc <= A;
                            lo  <= '1;
                        end else begin
                            acc <= '0;
                            lo  <= Operacao[1] ? A : B;
                        end
                    end
                end
                CALCULA: begin
                    acc  <= acc_prox;
                    lo   <= lo_prox;
                    cont <= cont - CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            Pronto      <= 1'b0;
            Hab_Escrita <= 1'b0;
            Div_Zero    <= 1'b0;
            Resultado   <= '0;
            Sel_SC      <= '0;
        end else begin
            Pronto      <= (estado == ESCREVE);
            Hab_Escrita <= (estado == ESCREVE);
            Div_Zero    <= (estado == ESCREVE) && reg_dz;
            if (estado == ESCREVE) begin
                Resultado <= selecionado;
                Sel_SC    <= reg_dest;
            end
        end
    end

endmodule

// File: tb/tb_ula_mul_div_seq.sv
module tb_ula_mul_div_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        Inicia;
    logic [1:0]  Operacao;
    logic [15:0] A, B;
    logic [1:0]  Sel_Destino;
    logic        Ocupado, Pronto, Hab_Escrita, Div_Zero;
    logic [15:0] Resultado;
    logic [1:0]  Sel_SC;

    int n_vec = 0;
    int n_err = 0;

    ula_mul_div_seq #(
        .bits_palavra (16),
        .end_registros(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .Inicia      (Inicia),
        .Operacao    (Operacao),
        .A           (A),
        .B           (B),
        .Sel_Destino (Sel_Destino),
        .Ocupado     (Ocupado),
        .Pronto      (Pronto),
        .Resultado   (Resultado),
        .Hab_Escrita (Hab_Escrita),
        .Sel_SC      (Sel_SC),
        .Div_Zero    (Div_Zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [1:0]  dest;
        logic [15:0] res;
        logic        dz;
        int          lat;     // edges from acceptance to the write strobe
        int          glitch;  // cycle of a stray Inicia during the op, 0 = none
    } vec_t;

    vec_t tab[18];

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nome, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit seen;
        int lat, ocup, extra;
        seen = 0; lat = 0; ocup = 0; extra = 0;
        @(negedge clock);
        A = v.a; B = v.b; Operacao = v.op; Sel_Destino = v.dest; Inicia = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == 1) Inicia = 1'b0;
            if (v.glitch != 0 && k == v.glitch) begin
                A = 16'h0009; B = 16'h0009; Inicia = 1'b1;
            end
            if (v.glitch != 0 && k == v.glitch + 1) Inicia = 1'b0;
            if (Hab_Escrita) begin
                seen = 1;
                lat  = k - 1;
                break;
            end
            if (Ocupado) ocup++;
        end
        chk($sformatf("v%0d write_seen", idx), 32'(seen), 32'd1);
        if (seen) begin
            chk($sformatf("v%0d latency", idx), lat, v.lat);
            chk($sformatf("v%0d Resultado", idx), 32'(Resultado), 32'(v.res));
            chk($sformatf("v%0d Sel_SC", idx), 32'(Sel_SC), 32'(v.dest));
            chk($sformatf("v%0d Div_Zero", idx), 32'(Div_Zero), 32'(v.dz));
            chk($sformatf("v%0d Pronto", idx), 32'(Pronto), 32'd1);
            chk($sformatf("v%0d Ocupado_at_write", idx), 32'(Ocupado), 32'd0);
            chk($sformatf("v%0d Ocupado_cycles", idx), ocup, v.lat);
        end
        @(negedge clock);
        chk($sformatf("v%0d Hab_after", idx), 32'(Hab_Escrita), 32'd0);
        chk($sformatf("v%0d Pronto_after", idx), 32'(Pronto), 32'd0);
        chk($sformatf("v%0d Div_Zero_after", idx), 32'(Div_Zero), 32'd0);
        chk($sformatf("v%0d Resultado_held", idx), 32'(Resultado), 32'(v.res));
        if (v.glitch != 0) begin
            for (int k = 0; k < 25; k++) begin
                @(negedge clock);
                if (Hab_Escrita || Pronto || Ocupado) extra++;
            end
            chk($sformatf("v%0d no_second_op", idx), extra, 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " Ocupado"},     32'(Ocupado),     32'd0);
        chk({tag, " Pronto"},      32'(Pronto),      32'd0);
        chk({tag, " Hab_Escrita"}, 32'(Hab_Escrita), 32'd0);
        chk({tag, " Resultado"},   32'(Resultado),   32'd0);
        chk({tag, " Sel_SC"},      32'(Sel_SC),      32'd0);
        chk({tag, " Div_Zero"},    32'(Div_Zero),    32'd0);
    endtask

    initial begin
        int activity;

        tab[0]  = '{16'd3,    16'd5,    2'b00, 2'd2, 16'h000F, 1'b0, 17, 0};
        tab[1]  = '{16'hFFFF, 16'hFFFF, 2'b01, 2'd1, 16'hFFFE, 1'b0, 17, 0};
        tab[2]  = '{16'hFFFF, 16'hFFFF, 2'b00, 2'd3, 16'h0001, 1'b0, 17, 0};
        tab[3]  = '{16'd100,  16'd7,    2'b10, 2'd0, 16'd14,   1'b0, 17, 0};
        tab[4]  = '{16'd100,  16'd7,    2'b11, 2'd1, 16'd2,    1'b0, 17, 0};
        tab[5]  = '{16'h1234, 16'h0000, 2'b10, 2'd2, 16'hFFFF, 1'b1, 1,  0};
        tab[6]  = '{16'h1234, 16'h0000, 2'b11, 2'd3, 16'h1234, 1'b1, 1,  0};
        tab[7]  = '{16'd3,    16'd5,    2'b00, 2'd2, 16'h000F, 1'b0, 17, 5};
        tab[8]  = '{16'h8000, 16'h0002, 2'b01, 2'd1, 16'h0001, 1'b0, 17, 0};
        tab[9]  = '{16'h8000, 16'h0002, 2'b00, 2'd0, 16'h0000, 1'b0, 17, 0};
        tab[10] = '{16'hFFFF, 16'h0001, 2'b10, 2'd2, 16'hFFFF, 1'b0, 17, 0};
        tab[11] = '{16'd5,    16'd9,    2'b11, 2'd3, 16'h0005, 1'b0, 17, 0};
        tab[12] = '{16'd5,    16'd9,    2'b10, 2'd1, 16'h0000, 1'b0, 17, 0};
        tab[13] = '{16'h1234, 16'h1234, 2'b10, 2'd2, 16'h0001, 1'b0, 17, 0};
        tab[14] = '{16'h00FF, 16'h0101, 2'b00, 2'd1, 16'hFFFF, 1'b0, 17, 0};
        tab[15] = '{16'h1234, 16'h0000, 2'b01, 2'd0, 16'h0000, 1'b0, 17, 0};
        tab[16] = '{16'hABCD, 16'h1234, 2'b10, 2'd2, 16'h0009, 1'b0, 17, 0};
        tab[17] = '{16'hABCD, 16'h1234, 2'b11, 2'd3, 16'h07F9, 1'b0, 17, 0};

        reset = 1'b1; Inicia = 1'b0; Operacao = 2'b00;
        A = '0; B = '0; Sel_Destino = '0;
        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;

        foreach (tab[i]) run_vec(tab[i], i);

        // Reset in the middle of a division, with Inicia raised alongside it.
        @(negedge clock);
        A = 16'd100; B = 16'd7; Operacao = 2'b10; Sel_Destino = 2'd1; Inicia = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) Inicia = 1'b0;
        end
        chk("midop Ocupado_before_reset", 32'(Ocupado), 32'd1);
        reset = 1'b1; Inicia = 1'b1;
        @(negedge clock);
        chk_all_zero("midop_reset");
        reset = 1'b0; Inicia = 1'b0;
        activity = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (Hab_Escrita || Pronto || Ocupado) activity++;
        end
        chk("midop no_write_after_reset", activity, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ula_mul_div_seq.md
Name: ula_mul_div_seq

Overview:
- Multi-cycle unsigned multiply/divide unit directly downstream of the register bank.
- Consumes the bank's A/B read outputs.
- Produces the write-back word for the bank's E input, plus the bank's write enable and destination select.
- Lets 16-bit MUL/DIV results return to the register bank without a combinational array.

Parameters:
- bits_palavra, 16, operand/result width W
- end_registros, 2, width of register-bank address

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clears FSM and all outputs
- Inicia  in  1  start request, sampled only in OCIOSO
- Operacao  in  2  00 MUL low half, 01 MUL high half, 10 DIV quotient, 11 DIV remainder
- A  in  bits_palavra  operand 1 / dividend (from bank output A)
- B  in  bits_palavra  operand 2 / divisor (from bank output B)
- Sel_Destino  in  end_registros  destination register for the result
- Ocupado  out  1  high from the cycle after Inicia is accepted through the ESCREVE cycle
- Pronto  out  1  one-cycle pulse, coincident with Hab_Escrita
- Resultado  out  bits_palavra  write-back word (to bank E)
- Hab_Escrita  out  1  one-cycle write strobe (to bank Hab_Escrita)
- Sel_SC  out  end_registros  latched destination (to bank Sel_SC)
- Div_Zero  out  1  high with Pronto when a DIV had B==0

Behaviour:
- Reset value of every output is 0. Reset forces OCIOSO, clears the counter and operand registers, and suppresses any pending write. It wins over Inicia in the same cycle and is effective mid-operation.
- States:
  - OCIOSO -> CALCULA on Inicia (normal case).
  - OCIOSO -> ESCREVE on Inicia with Operacao[1]=1 and B==0.
  - CALCULA -> ESCREVE when the counter reaches 0.
  - ESCREVE -> OCIOSO unconditionally.
- On acceptance, A, B, Operacao and Sel_Destino are latched. Later changes on the inputs have no effect on the running operation.
- The counter loads W and decrements once per CALCULA cycle. Exactly W CALCULA cycles are taken.
- MUL: unsigned shift-add, one multiplier bit per cycle, 2W-bit product register.
  - Op 00 returns product[W-1:0].
  - Op 01 returns product[2W-1:W].
- DIV: unsigned restoring, one quotient bit per cycle, W+1-bit partial remainder.
  - Op 10 returns the quotient.
  - Op 11 returns the remainder.
- Latency: if Inicia is sampled at edge t, Hab_Escrita/Pronto are high for the single cycle after edge t+W+1 (17 cycles for W=16). Ocupado goes low in the next cycle and a new Inicia may be sampled there.
- Divide by zero: no CALCULA; ESCREVE is entered at the next edge.
  - Quotient = all ones; remainder = A.
  - Div_Zero=1 for that cycle only.
- Inicia while Ocupado=1 is ignored; no queueing.
- Resultado and Sel_SC hold their last written values between operations. Hab_Escrita, Pronto and Div_Zero are 0 outside ESCREVE.
- Product and remainder arithmetic are width-exact: no truncation before final selection, no overflow flag.

Decomposition:
- Package ula_mul_div_pkg: state enum {OCIOSO, CALCULA, ESCREVE}; Operacao encodings OP_MUL_LO, OP_MUL_HI, OP_DIV_Q, OP_DIV_R; default width constants.
- One sub-module, nucleo_passo_mul_div: combinational single-iteration step (shift-add or restore-subtract) instanced inside the top.
- The FSM, counter and latches live in the top.

Test Plan:
- After reset: A=3, B=5, Operacao=00, Sel_Destino=2, Inicia pulse -> Hab_Escrita=1, Resultado=0x000F, Sel_SC=2 exactly 17 cycles later; Ocupado high 17 cycles.
- A=0xFFFF, B=0xFFFF, op 01 -> Resultado=0xFFFE. Repeat with op 00 -> Resultado=0x0001.
- A=100, B=7, op 10 -> Resultado=14; op 11 -> Resultado=2; Div_Zero=0 both.
- A=0x1234, B=0, op 10 -> Resultado=0xFFFF, Div_Zero=1, Pronto 2 cycles after Inicia. Op 11 -> Resultado=0x1234.
- Start 3*5, pulse Inicia with A=9, B=9 at cycle 5 -> ignored; single write of 0x000F; no second Pronto.
- Start 100/7, assert reset at cycle 8 -> all outputs 0 next cycle, no Hab_Escrita ever. Inicia asserted together with reset -> not accepted.
